// File: rtl/div_share_unit.sv
// Shared radix-2 restoring divide/remainder engine for two execute lanes.
// Lane 1 is older and is always served first; lane 2 follows when both request.
module div_share_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ReqE1,
    input  logic            ReqE2,
    input  logic [1:0]      DivOpE1,
    input  logic [1:0]      DivOpE2,
    input  logic [XLEN-1:0] SrcAE1,
    input  logic [XLEN-1:0] SrcBE1,
    input  logic [XLEN-1:0] SrcAE2,
    input  logic [XLEN-1:0] SrcBE2,
    input  logic            FlushE,
    output logic            StallDiv,
    output logic            Busy,
    output logic            DoneE1,
    output logic            DoneE2,
    output logic [XLEN-1:0] DivResultE1,
    output logic [XLEN-1:0] DivResultE2
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RUN1, LOAD2, RUN2, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] a_orig_q, a_orig_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic            pend2_q, pend2_d;
    logic            served1_q, served1_d;
    logic            busy_q, busy_d;
    logic            done1_q, done1_d;
    logic            done2_q, done2_d;
    logic [XLEN-1:0] res1_q, res1_d;
    logic [XLEN-1:0] res2_q, res2_d;

    logic            ld_lane2, ld_signed, ld_ovf, do_load;
    logic [1:0]      ld_op;
    logic [XLEN-1:0] ld_a, ld_b, ld_abs_a, ld_abs_b;

    logic [2*XLEN:0] pair_shift;
    logic [XLEN:0]   shifted, step_rem;
    logic [XLEN-1:0] step_quot, fin_quot, fin_rem, fin_result;
    logic            no_borrow;

    // Lane 2 operands are loaded in LOAD2, or straight from IDLE when lane 1 is silent.
    always_comb begin
        ld_lane2  = (state_q == LOAD2) || !ReqE1;
        ld_op     = ld_lane2 ? DivOpE2 : DivOpE1;
        ld_a      = ld_lane2 ? SrcAE2  : SrcAE1;
        ld_b      = ld_lane2 ? SrcBE2  : SrcBE1;
        ld_signed = !ld_op[0];
        ld_abs_a  = (ld_signed && ld_a[XLEN-1]) ? -ld_a : ld_a;
        ld_abs_b  = (ld_signed && ld_b[XLEN-1]) ? -ld_b : ld_b;
        ld_ovf    = ld_signed && (ld_a == MIN_NEG) && (ld_b == '1);
    end

    always_comb begin
        pair_shift = {rem_q, quot_q} << 1;
        shifted    = pair_shift[2*XLEN:XLEN];
        no_borrow  = shifted >= {1'b0, divisor_q};
        step_rem   = no_borrow ? (shifted - {1'b0, divisor_q}) : shifted;
        step_quot  = pair_shift[XLEN-1:0] | XLEN'(no_borrow);
        fin_quot   = q_neg_q ? -step_quot : step_quot;
        fin_rem    = r_neg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
        if (div_zero_q) begin
            fin_quot = '1;
            fin_rem  = a_orig_q;
        end else if (ovf_q) begin
            fin_quot = MIN_NEG;
            fin_rem  = '0;
        end
        fin_result = is_rem_q ? fin_rem : fin_quot;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        a_orig_d   = a_orig_q;
        is_rem_d   = is_rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        pend2_d    = pend2_q;
        served1_d  = served1_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        done1_d    = 1'b0;
        done2_d    = 1'b0;
        do_load    = 1'b0;

        if (FlushE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ReqE1 || ReqE2) begin
                        do_load   = 1'b1;
                        pend2_d   = ReqE1 && ReqE2;
                        served1_d = ReqE1;
                        state_d   = ReqE1 ? RUN1 : RUN2;
                    end
                end
                RUN1, RUN2: begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (state_q == RUN1) res1_d = fin_result;
                        else                 res2_d = fin_result;
                        if (state_q == RUN1 && pend2_q) begin
                            state_d = LOAD2;
                        end else begin
                            state_d = DONE;
                            done1_d = served1_q;
                            done2_d = (state_q == RUN2);
                        end
                    end
                end
                LOAD2: begin
                    do_load = 1'b1;
                    state_d = RUN2;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Signed operations run on magnitudes; signs are reapplied on the last step.
        if (do_load) begin
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = ld_abs_a;
            divisor_d  = ld_abs_b;
            a_orig_d   = ld_a;
            is_rem_d   = ld_op[1];
            q_neg_d    = ld_signed && (ld_a[XLEN-1] ^ ld_b[XLEN-1]);
            r_neg_d    = ld_signed && ld_a[XLEN-1];
            div_zero_d = (ld_b == '0);
            ovf_d      = ld_ovf;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            a_orig_q   <= '0;
            is_rem_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            pend2_q    <= 1'b0;
            served1_q  <= 1'b0;
            busy_q     <= 1'b0;
            done1_q    <= 1'b0;
            done2_q    <= 1'b0;
            res1_q     <= '0;
            res2_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            a_orig_q   <= a_orig_d;
            is_rem_q   <= is_rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            pend2_q    <= pend2_d;
            served1_q  <= served1_d;
            busy_q     <= busy_d;
            done1_q    <= done1_d;
            done2_q    <= done2_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
        end
    end

    assign StallDiv    = rst_n && !FlushE &&
                         (((state_q == IDLE) && (ReqE1 || ReqE2)) ||
                          (state_q == RUN1) || (state_q == LOAD2) || (state_q == RUN2));
    assign Busy        = busy_q;
    assign DoneE1      = done1_q;
    assign DoneE2      = done2_q;
    assign DivResultE1 = res1_q;
    assign DivResultE2 = res2_q;

endmodule

// File: doc/div_share_unit.md
# div_share_unit

Shared iterative divide/remainder engine for the dual-issue execute stage. Lanes 1 and 2 both issue RV32M DIV/DIVU/REM/REMU into one radix-2 restoring divider instead of each carrying its own. The unit arbitrates between lanes, sequences the 32-iteration divide, and drives a stall to the hazard unit while busy. It returns a registered result per lane.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- ReqE1 / ReqE2  in  1  lane 1 / lane 2 holds a divide-class instruction in Execute.
- DivOpE1 / DivOpE2  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcAE1, SrcBE1 / SrcAE2, SrcBE2  in  XLEN  post-forwarding dividend/divisor per lane.
- FlushE  in  1  kill of Execute-stage contents.
- StallDiv  out  1  freeze Fetch/Decode/Execute (combinational).
- Busy  out  1  state not IDLE (registered).
- DoneE1 / DoneE2  out  1  lane result valid this cycle.
- DivResultE1 / DivResultE2  out  XLEN  registered lane result.

## Operation
- States: IDLE, RUN1, LOAD2, RUN2, DONE.
- IDLE:
  - ReqE1 → latch lane 1 operands, go RUN1. Record whether ReqE2 is also pending.
  - Only ReqE2 → latch lane 2, go RUN2.
  - Lane 1 is older and always served first.
- Load step:
  - Signed ops (DIV/REM) take |A| and |B|.
  - Record quotient sign = signA XOR signB and remainder sign = signA.
  - Flag divisor-zero (B==0) and signed overflow (A==0x80000000, B==0xFFFFFFFF, signed op).
  - Iteration counter cleared to 0.
- RUNx: one restoring step per cycle, for 32 cycles (counter 0..31).
  - Shift {rem, quot} left by 1.
  - Trial-subtract |B|.
  - Keep the difference and set quot bit 0 if there is no borrow.
  - Remainder register is XLEN+1 bits.
- Final RUNx cycle (counter==31): apply sign fixup, select quotient or remainder, write DivResultEx. Overrides:
  - Divisor-zero: quotient = 0xFFFFFFFF; remainder = original A.
  - Overflow: quotient = 0x80000000; remainder = 0.
  - Special cases still take the full fixed latency.
- Next state after the final RUNx cycle:
  - RUN1 → LOAD2 if lane 2 is pending, else DONE.
  - RUN2 → DONE.
- LOAD2: latch lane 2 operands (held stable by the stall), go RUN2.
- DONE:
  - DoneE1/DoneE2 = 1 for each lane served in this sequence.
  - StallDiv = 0.
  - Requests are ignored this cycle.
  - Next state IDLE.
- StallDiv = !FlushE && ((IDLE && (ReqE1||ReqE2)) || RUN1 || LOAD2 || RUN2).
- FlushE high in any state:
  - Next state IDLE.
  - No Done pulse.
  - DivResultEx and the other lane's completed result are left unchanged.
  - A FlushE in IDLE prevents the load.
- Request deassertion mid-operation without FlushE is ignored; the operation completes.
- rst_n low at an edge:
  - State becomes IDLE.
  - Counter, operand registers, Busy, DoneE1/2, DivResultE1/2 all become 0.
  - Reset overrides FlushE and requests.

## Timing
- Cycle 0 is the IDLE cycle where the request is seen; StallDiv is high combinationally from cycle 0.
- Single lane: RUN cycles 1..32, DONE at cycle 33 (StallDiv low, Done high). Instruction leaves Execute at the end of cycle 33.
- Both lanes:
  - RUN1 cycles 1..32; DivResultE1 valid from cycle 33.
  - LOAD2 at cycle 33; RUN2 cycles 34..65.
  - DONE at cycle 66, with DoneE1 and DoneE2 both high.
- DivResultEx is stable from its write until the next load of that lane or reset.
- Back-to-back: the earliest new request is accepted in the IDLE cycle after DONE.
- Busy is high in RUN1, LOAD2, RUN2 and DONE.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with ReqE1=1 → all outputs 0, StallDiv=0 during reset, state IDLE.
- Single signed: lane 1 DIV 20 / −3 → StallDiv high cycles 0..32; DoneE1 at cycle 33; DivResultE1=0xFFFFFFFA. Repeat with REM → 0x00000002.
- Dual issue: lane 1 REMU 100 % 7, lane 2 DIV −100 / 7 → DivResultE1=2 from cycle 33; DivResultE2=0xFFFFFFF2; both Done at cycle 66; StallDiv high cycles 0..65.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM −5 % 0 → 0xFFFFFFFB.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM of the same operands → 0.
  - All of these Done at cycle 33.
- Flush: FlushE at cycle 10 of a RUN1 with both lanes requested → StallDiv low that cycle; IDLE next cycle; no Done; DivResultE1/E2 unchanged.
- Reset during RUN2 (cycle 50 of a dual sequence) → next cycle IDLE; DivResultE1=0; Busy=0; no Done pulse.
